// File: rtl/rx_frame_parser_pkg.sv
// Shared types and constants for the Ethernet receive frame parser.
// Holds the FSM state encoding, the header length and the broadcast address.
package rx_frame_parser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } rx_fsm_t;

    localparam int          ETH_HDR_BYTES = 14;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int          HDR_IDX_W     = 4;

    // True when a destination address is one this station listens to.
    function automatic logic mac_accepted(input logic [47:0] mac,
                                          input logic [47:0] local_mac);
        return (mac == local_mac) || (mac == BCAST_MAC);
    endfunction

endpackage

// File: rtl/rx_frame_parser_hdr_shift.sv
// rx_hdr_shift: 14-byte Ethernet header capture register.
// Each accepted header byte is written at the given byte index; the register
// is read out as destination address, source address and EtherType/length,
// first byte on the wire in the most significant position.
module rx_hdr_shift
    import rx_frame_parser_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [HDR_IDX_W-1:0] idx,
    input  logic [7:0]           data,
    output logic [47:0]          dst_mac,
    output logic [47:0]          src_mac,
    output logic [15:0]          len_type
);

    logic [ETH_HDR_BYTES-1:0][7:0] hdr_q;

    // Capture one header byte per accepted header beat.
    // NOTE: state is updated with <= so every register samples the pre-edge
    // values; blocking assignments here would create order-dependent logic.
    // NOTE: this small register array is reset because the header outputs
    // must read zero after reset; large data buffers are normally left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
        end else if (wr_en && (int'(idx) < ETH_HDR_BYTES)) begin
            hdr_q[idx] <= data;
        end
    end

    assign dst_mac  = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
    assign src_mac  = {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
    assign len_type = {hdr_q[12], hdr_q[13]};

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: Ethernet receive frame parser.
// Splits a MAC byte stream into a 14-byte header (captured in rx_hdr_shift)
// and a payload that is streamed into an external byte buffer. Runt frames,
// buffer overflow, payload-length overflow and MAC-flagged bad frames are
// reported with frame_err. Define RX_ADDR_FILTER_EN to silently discard
// frames whose destination is neither LOCAL_MAC nor broadcast.
module rx_frame_parser
    import rx_frame_parser_pkg::*;
#(
    parameter int          SIZE      = 2048,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    input  logic        btx_full,
    output logic        btx_wr_en,
    output logic [7:0]  btx_wr_data,
    output logic        rx_header_valid,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] len_type,
    output logic [15:0] payload_len,
    output logic        frame_err
);

    localparam logic [HDR_IDX_W-1:0] LAST_HDR_IDX = HDR_IDX_W'(ETH_HDR_BYTES - 1);
    localparam logic [15:0]          PLEN_MAX     = 16'(SIZE);

    rx_fsm_t              state;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic                 hdr_wr;
    logic [HDR_IDX_W-1:0] hdr_wr_idx;
`ifdef RX_ADDR_FILTER_EN
    logic                 filt_drop;
`endif

    // Steer the current byte into the header register while in IDLE/HDR.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hdr_wr     = 1'b0;
        hdr_wr_idx = hdr_idx;
        unique case (state)
            IDLE: begin
                hdr_wr     = rx_tvalid && !rx_tlast;
                hdr_wr_idx = '0;
            end
            HDR:     hdr_wr = rx_tvalid;
            default: ;
        endcase
    end

    rx_hdr_shift u_hdr_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (hdr_wr),
        .idx      (hdr_wr_idx),
        .data     (rx_tdata),
        .dst_mac  (dst_mac),
        .src_mac  (src_mac),
        .len_type (len_type)
    );

    // Frame FSM with registered buffer strobe, payload count and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hdr_idx         <= '0;
            payload_len     <= '0;
            btx_wr_en       <= 1'b0;
            btx_wr_data     <= '0;
            rx_header_valid <= 1'b0;
            frame_err       <= 1'b0;
`ifdef RX_ADDR_FILTER_EN
            filt_drop       <= 1'b0;
`endif
        end else begin
            btx_wr_en       <= 1'b0;
            rx_header_valid <= 1'b0;
            frame_err       <= 1'b0;
            // Idle beats (rx_tvalid low) leave every counter and the state alone.
            if (rx_tvalid) begin
                unique case (state)
                    IDLE: begin
                        payload_len <= '0;
`ifdef RX_ADDR_FILTER_EN
                        filt_drop   <= 1'b0;
`endif
                        if (rx_tlast) begin
                            frame_err <= 1'b1;
                        end else begin
                            hdr_idx <= HDR_IDX_W'(1);
                            state   <= HDR;
                        end
                    end
                    HDR: begin
                        if (rx_tlast) begin
                            // Runt: frame ended before any payload byte.
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (hdr_idx == LAST_HDR_IDX) begin
                            state <= PAYLOAD;
`ifdef RX_ADDR_FILTER_EN
                        end else if ((hdr_idx == HDR_IDX_W'(5)) &&
                                     !mac_accepted({dst_mac[47:8], rx_tdata}, LOCAL_MAC)) begin
                            filt_drop <= 1'b1;
                            state     <= DROP;
`endif
                        end else begin
                            hdr_idx <= hdr_idx + HDR_IDX_W'(1);
                        end
                    end
                    PAYLOAD: begin
                        if (btx_full || (payload_len >= PLEN_MAX)) begin
                            // Overflow: this byte is not written. If it is also
                            // the last byte, close the frame right away.
                            if (rx_tlast) begin
                                rx_header_valid <= 1'b1;
                                frame_err       <= 1'b1;
                                state           <= IDLE;
                            end else begin
                                state <= DROP;
                            end
                        end else begin
                            btx_wr_en   <= 1'b1;
                            btx_wr_data <= rx_tdata;
                            payload_len <= payload_len + 16'd1;
                            if (rx_tlast) begin
                                rx_header_valid <= 1'b1;
                                frame_err       <= rx_tuser;
                                state           <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (rx_tlast) begin
                            state <= IDLE;
`ifdef RX_ADDR_FILTER_EN
                            // Filtered frames vanish; overflowed ones report
                            // how many bytes reached the buffer.
                            if (!filt_drop) begin
                                rx_header_valid <= 1'b1;
                                frame_err       <= 1'b1;
                            end
`else
                            rx_header_valid <= 1'b1;
                            frame_err       <= 1'b1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser. A frame-level model turns each
// generated frame into the list of bytes that must reach the buffer and the
// status event that must follow; a monitor compares every output beat.
module tb_rx_frame_parser;
    import rx_frame_parser_pkg::*;

    localparam int          TB_SIZE = 64;
    localparam logic [47:0] TB_MAC  = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_tdata = '0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic        rx_tuser = 1'b0;
    logic        btx_full = 1'b0;
    logic        btx_wr_en;
    logic [7:0]  btx_wr_data;
    logic        rx_header_valid;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] len_type;
    logic [15:0] payload_len;
    logic        frame_err;

    always #5 clk = ~clk;

    rx_frame_parser #(.SIZE(TB_SIZE), .LOCAL_MAC(TB_MAC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_tdata        (rx_tdata),
        .rx_tvalid       (rx_tvalid),
        .rx_tlast        (rx_tlast),
        .rx_tuser        (rx_tuser),
        .btx_full        (btx_full),
        .btx_wr_en       (btx_wr_en),
        .btx_wr_data     (btx_wr_data),
        .rx_header_valid (rx_header_valid),
        .dst_mac         (dst_mac),
        .src_mac         (src_mac),
        .len_type        (len_type),
        .payload_len     (payload_len),
        .frame_err       (frame_err)
    );

    typedef struct {
        bit          hv;
        bit          err;
        int          plen;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
    } evt_t;

    evt_t        exp_evt[$];
    logic [7:0]  exp_wr[$];
    logic [7:0]  fr[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt_wr = 0, cnt_hv = 0, cnt_err = 0, cnt_both = 0;
    int          s_wr, s_hv, s_err, s_both;
    int          last_plen = 0;
    logic [47:0] last_src = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    task automatic model_frame(input bit tuser, input int full_at);
        int          n;
        int          npay;
        int          p;
        evt_t        e;
        logic [47:0] d;
        n = fr.size();
        d = '0;
        if (n >= 6) d = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
`ifdef RX_ADDR_FILTER_EN
        if (n > 6 && d != TB_MAC && d != BCAST_MAC) return;
`endif
        e.hv = 0; e.err = 1; e.plen = 0; e.dst = '0; e.src = '0; e.typ = '0;
        if (n < ETH_HDR_BYTES + 1) begin
            exp_evt.push_back(e);
            return;
        end
        npay = n - ETH_HDR_BYTES;
        p = npay;
        for (int i = 0; i < npay; i++) begin
            if ((full_at >= 0 && i >= full_at) || i >= TB_SIZE) begin
                p = i;
                break;
            end
        end
        for (int i = 0; i < p; i++) exp_wr.push_back(fr[ETH_HDR_BYTES + i]);
        e.hv   = 1;
        e.err  = (p < npay) ? 1'b1 : tuser;
        e.plen = p;
        e.dst  = d;
        e.src  = {fr[6], fr[7], fr[8], fr[9], fr[10], fr[11]};
        e.typ  = {fr[12], fr[13]};
        exp_evt.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    task automatic build_frame(input int n, input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] typ);
        logic [7:0] h [14];
        for (int i = 0; i < 6; i++) begin
            h[i]     = d[47 - 8*i -: 8];
            h[6 + i] = s[47 - 8*i -: 8];
        end
        h[12] = typ[15:8];
        h[13] = typ[7:0];
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back((i < 14) ? h[i] : 8'($urandom));
    endtask

    // Idle beats carry junk on every other input to show it is ignored.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            rx_tvalid = 1'b0;
            rx_tdata  = 8'($urandom);
            rx_tlast  = 1'($urandom);
            rx_tuser  = 1'($urandom);
            btx_full  = 1'($urandom);
            @(posedge clk); #1;
        end
        rx_tlast = 1'b0; rx_tuser = 1'b0; btx_full = 1'b0;
    endtask

    task automatic drive_byte(input int i, input bit tuser, input int full_at);
        rx_tvalid = 1'b1;
        rx_tdata  = fr[i];
        rx_tlast  = (i == fr.size() - 1);
        rx_tuser  = tuser && (i == fr.size() - 1);
        btx_full  = (full_at >= 0) && (i >= ETH_HDR_BYTES + full_at);
        @(posedge clk); #1;
    endtask

    // gap_mode: 0 = continuous, 1 = valid toggles 1/0, 2 = random gaps.
    task automatic send_frame(input bit tuser, input int full_at, input int gap_mode);
        model_frame(tuser, full_at);
        for (int i = 0; i < fr.size(); i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            else if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive_byte(i, tuser, full_at);
        end
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; btx_full = 1'b0;
    endtask

    task automatic snap();
        s_wr = cnt_wr; s_hv = cnt_hv; s_err = cnt_err; s_both = cnt_both;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"},  btx_wr_en, 0);
        check({tag, "_wr_data"}, btx_wr_data, 0);
        check({tag, "_hv"},     rx_header_valid, 0);
        check({tag, "_err"},    frame_err, 0);
        check({tag, "_dst"},    dst_mac, 0);
        check({tag, "_src"},    src_mac, 0);
        check({tag, "_type"},   len_type, 0);
        check({tag, "_plen"},   payload_len, 0);
    endtask

    // ---------------- monitor ----------------
    logic       s_valid = 1'b0, s_last = 1'b0;
    logic [7:0] s_data = '0;
    evt_t       mon_e;

    always @(posedge clk) begin
        s_valid <= rx_tvalid;
        s_last  <= rx_tvalid && rx_tlast;
        s_data  <= rx_tdata;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (btx_wr_en) begin
                cnt_wr++;
                check("wr_latency", {s_valid, s_data}, {1'b1, btx_wr_data});
                check("wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) check("wr_data", btx_wr_data, exp_wr.pop_front());
            end
            if (rx_header_valid || frame_err) begin
                cnt_hv   += int'(rx_header_valid);
                cnt_err  += int'(frame_err);
                cnt_both += int'(rx_header_valid && frame_err);
                if (rx_header_valid) begin
                    last_plen = int'(payload_len);
                    last_src  = src_mac;
                end
                check("evt_latency", s_last, 1);
                check("evt_expected", exp_evt.size() > 0, 1);
                if (exp_evt.size() > 0) begin
                    mon_e = exp_evt.pop_front();
                    check("evt_hv",  rx_header_valid, mon_e.hv);
                    check("evt_err", frame_err, mon_e.err);
                    if (mon_e.hv) begin
                        check("evt_plen", payload_len, mon_e.plen);
                        check("evt_dst",  dst_mac, mon_e.dst);
                        check("evt_src",  src_mac, mon_e.src);
                        check("evt_type", len_type, mon_e.typ);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          n, full_at, gap;
        bit          tu;
        logic [47:0] d;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst_in");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("rst_out");

        // 64-byte good frame to the station address.
        build_frame(64, TB_MAC, 48'hA0_B1_C2_D3_E4_F5, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(3);
        check("good64_writes", cnt_wr - s_wr, 50);
        check("good64_hv", cnt_hv - s_hv, 1);
        check("good64_err", cnt_err - s_err, 0);
        check("good64_plen", last_plen, 50);
        check("good64_type_hold", len_type, 16'h0800);
        check("good64_dst_hold", dst_mac, TB_MAC);

        // 10-byte runt.
        build_frame(10, TB_MAC, 48'h11_22_33_44_55_66, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(3);
        check("runt10_writes", cnt_wr - s_wr, 0);
        check("runt10_err", cnt_err - s_err, 1);
        check("runt10_hv", cnt_hv - s_hv, 0);

        // 100-byte frame, buffer full from payload byte 20.
        build_frame(100, TB_MAC, 48'h11_22_33_44_55_66, 16'h86DD);
        snap(); send_frame(0, 20, 0); idle(3);
        check("full20_writes", cnt_wr - s_wr, 20);
        check("full20_hv", cnt_hv - s_hv, 1);
        check("full20_err", cnt_err - s_err, 1);
        check("full20_plen", last_plen, 20);

        // 60-byte frame flagged bad by the MAC.
        build_frame(60, TB_MAC, 48'h11_22_33_44_55_66, 16'h0800);
        snap(); send_frame(1, -1, 0); idle(3);
        check("tuser60_writes", cnt_wr - s_wr, 46);
        check("tuser60_same_cycle", cnt_both - s_both, 1);

        // Header-length and payload-limit boundaries.
        build_frame(1, TB_MAC, 48'h0, 16'h0);
        snap(); send_frame(0, -1, 0); idle(2);
        check("len1_err", cnt_err - s_err, 1);
        build_frame(14, TB_MAC, 48'h1, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(2);
        check("len14_err", cnt_err - s_err, 1);
        check("len14_hv", cnt_hv - s_hv, 0);
        build_frame(15, TB_MAC, 48'h2, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(2);
        check("len15_writes", cnt_wr - s_wr, 1);
        build_frame(14 + TB_SIZE, TB_MAC, 48'h3, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(2);
        check("at_size_writes", cnt_wr - s_wr, TB_SIZE);
        check("at_size_err", cnt_err - s_err, 0);
        build_frame(15 + TB_SIZE, TB_MAC, 48'h4, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(2);
        check("over_size_plen", last_plen, TB_SIZE);
        check("over_size_err", cnt_err - s_err, 1);

        // Back-to-back frames, second with valid toggling.
        build_frame(64, TB_MAC, 48'hAA_00_00_00_00_01, 16'h0800);
        snap(); send_frame(0, -1, 0);
        build_frame(64, BCAST_MAC, 48'hBB_00_00_00_00_02, 16'h0806);
        send_frame(0, -1, 1); idle(3);
        check("b2b_writes", cnt_wr - s_wr, 100);
        check("b2b_hv", cnt_hv - s_hv, 2);
        check("b2b_src2", last_src, 48'hBB_00_00_00_00_02);

        // Reset in the middle of a header; the rest forms a new frame.
        build_frame(40, TB_MAC, 48'hCC_00_00_00_00_03, 16'h0800);
        for (int i = 0; i < 8; i++) drive_byte(i, 0, -1);
        rx_tvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_zero_outputs("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        fr = fr[8:$];
        snap(); send_frame(0, -1, 0); idle(3);
        check("midrst_writes", cnt_wr - s_wr, 18);
        check("midrst_err", cnt_err - s_err, 0);

`ifdef RX_ADDR_FILTER_EN
        build_frame(64, 48'h02_00_00_00_00_99, 48'h5, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(3);
        check("filt_other_writes", cnt_wr - s_wr, 0);
        check("filt_other_pulses", (cnt_hv - s_hv) + (cnt_err - s_err), 0);
        build_frame(64, BCAST_MAC, 48'h6, 16'h0800);
        snap(); send_frame(0, -1, 0); idle(3);
        check("filt_bcast_writes", cnt_wr - s_wr, 50);
        check("filt_bcast_hv", cnt_hv - s_hv, 1);
`endif

        // Randomized frames against the model.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) == 0) n = $urandom_range(1, 14);
            else n = $urandom_range(15, 100);
            case ($urandom_range(0, 3))
                0:       d = BCAST_MAC;
                1:       d = {16'($urandom), 32'($urandom)};
                default: d = TB_MAC;
            endcase
            tu = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) full_at = $urandom_range(0, 70);
            else full_at = -1;
            gap = ($urandom_range(0, 1) == 0) ? 0 : 2;
            build_frame(n, d, {16'($urandom), 32'($urandom)}, 16'($urandom));
            send_frame(tu, full_at, gap);
            idle($urandom_range(0, 2));
        end
        idle(5);
        check("drain_writes", exp_wr.size(), 0);
        check("drain_events", exp_evt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
